// File: rtl/checker_stream_arbiter.sv
// Round-robin arbiter that lends one cpu_checker to N_REQ record streams and returns tagged results.
// Optional stall timeout with forced record close: define CSA_TIMEOUT_EN.
module checker_stream_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned IDW       = 2,
  parameter logic [7:0]  IDLE_CHAR = 8'h00,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_char,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         chk_char,
  input  logic [1:0]         chk_format,
  input  logic [3:0]         chk_error,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [1:0]         res_format,
  output logic [3:0]         res_error,
  output logic [7:0]         res_len,
  output logic               res_aborted,
  output logic               busy
);

  localparam logic [7:0] END_CHAR = 8'h23;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_SAMPLE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [7:0]     len_q, len_d;
  logic           abort_q, abort_d;

  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q, res_id_d;
  logic [1:0]     res_format_q, res_format_d;
  logic [3:0]     res_error_q, res_error_d;
  logic [7:0]     res_len_q, res_len_d;
  logic           res_aborted_q, res_aborted_d;

`ifdef CSA_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0]  stall_q, stall_d;
`endif

  logic [7:0]     cur_char;
  logic [7:0]     len_inc;
  logic [IDW-1:0] next_ptr;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand;
  logic           found;

  assign cur_char = req_char[{grant_q, 3'b000} +: 8];
  assign len_inc  = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
  assign next_ptr = (grant_q == IDW'(N_REQ - 1)) ? '0 : grant_q + IDW'(1);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    len_d         = len_q;
    abort_d       = abort_q;
    res_valid_d   = 1'b0;
    res_id_d      = res_id_q;
    res_format_d  = res_format_q;
    res_error_d   = res_error_q;
    res_len_d     = res_len_q;
    res_aborted_d = res_aborted_q;
`ifdef CSA_TIMEOUT_EN
    stall_d       = stall_q;
`endif
    chk_char      = IDLE_CHAR;
    req_ready     = '0;
    cand_sum      = '0;
    cand          = '0;
    found         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Scan starting at rr_ptr, wrapping modulo N_REQ (N_REQ need not be a power of two).
        for (int unsigned i = 0; i < N_REQ; i++) begin
          cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(i);
          if (cand_sum >= (IDW+1)'(N_REQ)) cand_sum = cand_sum - (IDW+1)'(N_REQ);
          cand = cand_sum[IDW-1:0];
          if (!found && req_valid[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) begin
          state_d = ST_FWD;
          len_d   = '0;
          abort_d = 1'b0;
`ifdef CSA_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      ST_FWD: begin
        req_ready[grant_q] = 1'b1;
        if (req_valid[grant_q]) begin
          chk_char = cur_char;
          len_d    = len_inc;
`ifdef CSA_TIMEOUT_EN
          stall_d  = '0;
`endif
          if (cur_char == END_CHAR) begin
            state_d  = ST_SAMPLE;
            rr_ptr_d = next_ptr;
          end
        end else begin
          abort_d = 1'b1;
`ifdef CSA_TIMEOUT_EN
          // Close the checker's record ourselves so it stays in sync; the source is not popped.
          if (stall_q == SW'(TIMEOUT - 1)) begin
            chk_char  = END_CHAR;
            req_ready = '0;
            len_d     = len_inc;
            state_d   = ST_SAMPLE;
            rr_ptr_d  = next_ptr;
          end else begin
            stall_d = stall_q + SW'(1);
          end
`endif
        end
      end
      ST_SAMPLE: begin
        res_valid_d   = 1'b1;
        res_id_d      = grant_q;
        res_format_d  = abort_q ? 2'd0 : chk_format;
        res_error_d   = abort_q ? 4'd0 : chk_error;
        res_len_d     = len_q;
        res_aborted_d = abort_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      len_q         <= '0;
      abort_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_format_q  <= '0;
      res_error_q   <= '0;
      res_len_q     <= '0;
      res_aborted_q <= 1'b0;
`ifdef CSA_TIMEOUT_EN
      stall_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      len_q         <= len_d;
      abort_q       <= abort_d;
      res_valid_q   <= res_valid_d;
      res_id_q      <= res_id_d;
      res_format_q  <= res_format_d;
      res_error_q   <= res_error_d;
      res_len_q     <= res_len_d;
      res_aborted_q <= res_aborted_d;
`ifdef CSA_TIMEOUT_EN
      stall_q       <= stall_d;
`endif
    end
  end

  assign res_valid   = res_valid_q;
  assign res_id      = res_id_q;
  assign res_format  = res_format_q;
  assign res_error   = res_error_q;
  assign res_len     = res_len_q;
  assign res_aborted = res_aborted_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
